rr_arbiter4x16: RTL and testbench

- Round-robin arbiter and scheduler that shares one 16-bit output channel among four requesters.
- Drives the select of the team's existing 4-way 16-bit mux (mux4way16_gate) and registers the chosen word into a valid/ready output stage.
- Sits between four producer blocks and a single consumer.
- Fairness: no requester starves while the consumer keeps accepting.

---
 rtl/arb_pkg.sv | 16 +
 rtl/mux4way16_gate.sv | 18 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_arbiter4x16.sv | 80 ++++++++
 tb/tb_rr_arbiter4x16.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 4x16 round-robin arbiter
package arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] gnt_idx_t;

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    // mux4way16_gate decodes its select bit-reversed: 0->00, 1->10, 2->01, 3->11
    function automatic logic [1:0] idx_to_sel(input gnt_idx_t idx);
        return {idx[0], idx[1]};
    endfunction

endpackage

// File: rtl/mux4way16_gate.sv
// rtl/mux4way16_gate.sv - existing 4-way 16-bit mux (sel 00=a, 10=b, 01=c, 11=d)
module mux4way16_gate (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);

    logic [15:0] ab;
    logic [15:0] cd;

    assign ab  = sel[1] ? b : a;
    assign cd  = sel[1] ? d : c;
    assign out = sel[0] ? cd : ab;

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin picker scanning from ptr upward
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] in_valid,
    input  gnt_idx_t   ptr,
    output logic       any,
    output gnt_idx_t   gnt,
    output logic [3:0] onehot
);

    always_comb begin
        gnt_idx_t idx;
        any    = 1'b0;
        gnt    = '0;
        onehot = '0;
        idx    = ptr;
        // scan farthest first so the nearest valid requester overwrites last
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + gnt_idx_t'(k);
            if (in_valid[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
        if (any) begin
            onehot = 4'b0001 << gnt;
        end
    end

endmodule

// File: rtl/rr_arbiter4x16.sv
// rtl/rr_arbiter4x16.sv - 4-requester round-robin arbiter into a valid/ready stage; ARB_LOCK_EN adds in_lock
module rr_arbiter4x16
    import arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
`ifdef ARB_LOCK_EN
    input  logic [3:0]       in_lock,
`endif
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_gnt
);

    logic             state;
    gnt_idx_t         ptr;
    gnt_idx_t         gnt;
    gnt_idx_t         ptr_next;
    logic             any;
    logic [3:0]       onehot;
    logic             accept;
    logic [WIDTH-1:0] mux_out;

    rr_pick4 u_pick (
        .in_valid (in_valid),
        .ptr      (ptr),
        .any      (any),
        .gnt      (gnt),
        .onehot   (onehot)
    );

    mux4way16_gate u_mux (
        .a   (in_data0),
        .b   (in_data1),
        .c   (in_data2),
        .d   (in_data3),
        .sel (idx_to_sel(gnt)),
        .out (mux_out)
    );

    assign out_valid = (state == FULL);
    assign accept    = !out_valid || out_ready;
    assign in_ready  = (!reset && accept) ? onehot : 4'b0000;

`ifdef ARB_LOCK_EN
    // a locked grant keeps top priority for the next cycle
    assign ptr_next = in_lock[gnt] ? gnt : gnt + 2'd1;
`else
    assign ptr_next = gnt + 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_gnt  <= '0;
            ptr      <= gnt_idx_t'(RESET_PTR);
        end else if (accept) begin
            if (any) begin
                state    <= FULL;
                out_data <= mux_out;
                out_gnt  <= gnt;
                ptr      <= ptr_next;
            end else begin
                state    <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter4x16.sv
// tb/tb_rr_arbiter4x16.sv - directed self-checking bench for rr_arbiter4x16
module tb_rr_arbiter4x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_valid = 4'b0000;
    logic [15:0] in_data0 = 16'h0000;
    logic [15:0] in_data1 = 16'h0000;
    logic [15:0] in_data2 = 16'h0000;
    logic [15:0] in_data3 = 16'h0000;
    logic [3:0]  in_lock = 4'b0000;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_gnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter4x16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
`ifdef ARB_LOCK_EN
        .in_lock   (in_lock),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_gnt   (out_gnt)
    );

    task automatic set_fair_data();
        in_data0 = 16'hA000;
        in_data1 = 16'hA001;
        in_data2 = 16'hA002;
        in_data3 = 16'hA003;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        set_fair_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_cmp++; if (out_gnt !== 2'd0) begin n_fail++; $display("FAIL reset_out_gnt got=%0d exp=0", out_gnt); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL release_in_ready got=%b exp=0001", in_ready); end
    endtask

    task automatic test_fairness();
        logic [1:0] eg;
        for (int k = 0; k < 8; k++) begin
            eg = 2'(k % 4);
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid[%0d] got=%b exp=1", k, out_valid); end
            n_cmp++; if (out_gnt !== eg) begin n_fail++; $display("FAIL fair_gnt[%0d] got=%0d exp=%0d", k, out_gnt, eg); end
            n_cmp++; if (out_data !== (16'hA000 + 16'(eg))) begin n_fail++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, out_data, 16'hA000 + 16'(eg)); end
        end
    endtask

    task automatic test_select();
        @(negedge clk);
        in_valid = 4'b0010;
        in_data1 = 16'h1111;
        in_data2 = 16'h2222;
        @(posedge clk);
        #1;
        n_cmp++; if (out_data !== 16'h1111) begin n_fail++; $display("FAIL sel1_data got=%h exp=1111", out_data); end
        n_cmp++; if (out_gnt !== 2'd1) begin n_fail++; $display("FAIL sel1_gnt got=%0d exp=1", out_gnt); end
        @(negedge clk);
        in_valid = 4'b0100;
        @(posedge clk);
        #1;
        n_cmp++; if (out_data !== 16'h2222) begin n_fail++; $display("FAIL sel2_data got=%h exp=2222", out_data); end
        n_cmp++; if (out_gnt !== 2'd2) begin n_fail++; $display("FAIL sel2_gnt got=%0d exp=2", out_gnt); end
    endtask

    task automatic test_backpressure();
        // ptr=3 here, so requester 3 wins first
        @(negedge clk);
        set_fair_data();
        in_valid = 4'b1111;
        @(posedge clk);
        #1;
        n_cmp++; if (out_gnt !== 2'd3) begin n_fail++; $display("FAIL bp_first_gnt got=%0d exp=3", out_gnt); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_data !== 16'hA003) begin n_fail++; $display("FAIL bp_hold_data[%0d] got=%h exp=a003", k, out_data); end
            n_cmp++; if (out_gnt !== 2'd3) begin n_fail++; $display("FAIL bp_hold_gnt[%0d] got=%0d exp=3", k, out_gnt); end
            n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0000", k, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_gnt !== 2'd0 || out_data !== 16'hA000) begin
            n_fail++; $display("FAIL bp_refill got=%b/%0d/%h exp=1/0/a000", out_valid, out_gnt, out_data);
        end
    endtask

    task automatic test_mid_reset();
        // ptr=1 here; only requester 0 valid
        @(negedge clk);
        in_valid = 4'b0001;
        in_data0 = 16'hBEEF;
        @(posedge clk);
        #1;
        n_cmp++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL mr_load got=%h exp=beef", out_data); end
        @(negedge clk);
        out_ready = 1'b0;
        reset = 1'b1;
        in_valid = 4'b1111;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL mr_in_ready got=%b exp=0000", in_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL mr_data got=%h exp=0000", out_data); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_ptr got=%b exp=0001", in_ready); end
    endtask

    task automatic test_idle_and_single();
        // grant 0 (ptr->1), then an empty cycle drains and holds data/gnt
        out_ready = 1'b1;
        set_fair_data();
        @(posedge clk);
        @(negedge clk);
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 16'hA000 || out_gnt !== 2'd0) begin n_fail++; $display("FAIL idle_hold got=%h/%0d exp=a000/0", out_data, out_gnt); end
        @(negedge clk);
        in_valid = 4'b1111;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL idle_ptr got=%b exp=0010", in_ready); end
        in_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_gnt !== 2'd3 || out_data !== 16'hA003) begin
                n_fail++; $display("FAIL single[%0d] got=%b/%0d/%h exp=1/3/a003", k, out_valid, out_gnt, out_data);
            end
        end
        @(negedge clk);
        in_valid = 4'b1111;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr got=%b exp=0001", in_ready); end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_seq [6];
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        // ptr is 0; granting requester 1 moves ptr to 2
        in_valid = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        in_valid = 4'b1101;
        in_lock = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_gnt !== exp_seq[k]) begin n_fail++; $display("FAIL lock_gnt[%0d] got=%0d exp=%0d", k, out_gnt, exp_seq[k]); end
            if (k == 2) begin
                @(negedge clk);
                in_lock = 4'b0000;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_select();
        test_backpressure();
        test_mid_reset();
        test_idle_and_single();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
